// File: rtl/instr_rom_uart_loader_pkg.sv
// Shared constants, RX state encoding and baud divider helper for the UART-loaded
// instruction ROM.
package instr_rom_uart_loader_pkg;

  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/instr_rom_uart_loader_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, start-bit glitch rejection and mid-bit
// sampling. Emits a single-cycle byte_valid_o for each correctly framed byte.
module uart_rx_byte
  import instr_rom_uart_loader_pkg::*;
#(
  parameter int unsigned ClksPerBit = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o
);

  localparam int unsigned CntW = $clog2(ClksPerBit + 1);
  localparam logic [CntW-1:0] BitEnd  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(ClksPerBit / 2 - 1);

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;

  // Synchronizer resets to the idle-high line level so reset cannot fake a start edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (rx_prev_q && !rx_sync_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfEnd) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == BitEnd) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == BitEnd) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A low stop bit is a framing error: the byte is silently dropped.
  always_comb begin
    byte_valid_d = (state_q == StStop) && (cnt_q == BitEnd) && rx_sync_q;
    byte_o       = shift_q;
    byte_valid_o = byte_valid_q;
  end

endmodule

// File: rtl/instr_rom_uart_loader.sv
// Boot-time instruction memory: pairs UART bytes big-endian into instructions,
// stops on line-idle timeout or full memory, and serves a registered read port.
module instr_rom_uart_loader
  import instr_rom_uart_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned IDLE_BITS   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx,
  input  logic [ADDR_W-1:0] i_addr_read,
  output logic [DATA_W-1:0] o_instr_read,
  output logic              o_instr_transmit_done,
  output logic [ADDR_W-1:0] o_max_addr
);

  localparam int unsigned ClksPerBit = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int unsigned IdleEnd    = IDLE_BITS * ClksPerBit;
  localparam int unsigned IdleW      = $clog2(IdleEnd + 1);

  logic [7:0] rx_byte;
  logic       rx_valid;

  uart_rx_byte #(
    .ClksPerBit(ClksPerBit)
  ) u_rx (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .rx_i        (i_rx),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid)
  );

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] max_addr_q, max_addr_d;
  logic [7:0]        hold_q, hold_d;
  logic              high_phase_q, high_phase_d;
  logic              done_q, done_d;
  logic              got_byte_q, got_byte_d;
  logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;
  logic [DATA_W-1:0] instr_q;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q       <= '0;
      max_addr_q   <= '0;
      hold_q       <= '0;
      high_phase_q <= 1'b1;
      done_q       <= 1'b0;
      got_byte_q   <= 1'b0;
      idle_cnt_q   <= '0;
    end else begin
      wptr_q       <= wptr_d;
      max_addr_q   <= max_addr_d;
      hold_q       <= hold_d;
      high_phase_q <= high_phase_d;
      done_q       <= done_d;
      got_byte_q   <= got_byte_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  always_comb begin
    wptr_d       = wptr_q;
    max_addr_d   = max_addr_q;
    hold_d       = hold_q;
    high_phase_d = high_phase_q;
    done_d       = done_q;
    got_byte_d   = got_byte_q;
    idle_cnt_d   = idle_cnt_q;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    if (!done_q) begin
      if (rx_valid) begin
        got_byte_d = 1'b1;
        idle_cnt_d = '0;
        if (high_phase_q) begin
          hold_d       = rx_byte;
          high_phase_d = 1'b0;
        end else begin
          mem_we       = 1'b1;
          mem_wdata    = DATA_W'({hold_q, rx_byte});
          max_addr_d   = wptr_q;
          wptr_d       = wptr_q + 1'b1;
          high_phase_d = 1'b1;
          // No wrap: the last slot ends loading at once.
          if (wptr_q == '1) done_d = 1'b1;
        end
      end else if (got_byte_q) begin
        if (idle_cnt_q == IdleW'(IdleEnd)) begin
          done_d = 1'b1;
          if (!high_phase_q) begin
            mem_we     = 1'b1;
            mem_wdata  = DATA_W'({hold_q, 8'h00});
            max_addr_d = wptr_q;
          end
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
    end
  end

  // Contents survive reset; only the loader pointer restarts.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[wptr_q] <= mem_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      instr_q <= '0;
    end else begin
      instr_q <= mem[i_addr_read];
    end
  end

  assign o_instr_read          = instr_q;
  assign o_instr_transmit_done = done_q;
  assign o_max_addr            = max_addr_q;

endmodule

// File: tb/tb_instr_rom_uart_loader.sv
// Directed bench: dut1 runs the boot/load scenarios, dut2 (4-entry memory) covers
// the memory-full stop.
module tb_instr_rom_uart_loader;

  localparam int unsigned ClkHz  = 5_000_000;
  localparam int unsigned Baud   = 115200;
  localparam int          BitClk = 43;  // 5e6 / 115200, truncated

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx1 = 1'b1;
  logic        rx2 = 1'b1;
  logic [7:0]  addr1 = '0;
  logic [1:0]  addr2 = '0;
  logic [15:0] instr1, instr2;
  logic        done1, done2;
  logic [7:0]  max1;
  logic [1:0]  max2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_rom_uart_loader #(
    .CLK_FREQ_HZ(ClkHz),
    .BAUD       (Baud),
    .ADDR_W     (8),
    .DATA_W     (16),
    .IDLE_BITS  (16)
  ) dut1 (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_rx                 (rx1),
    .i_addr_read          (addr1),
    .o_instr_read         (instr1),
    .o_instr_transmit_done(done1),
    .o_max_addr           (max1)
  );

  instr_rom_uart_loader #(
    .CLK_FREQ_HZ(ClkHz),
    .BAUD       (Baud),
    .ADDR_W     (2),
    .DATA_W     (16),
    .IDLE_BITS  (16)
  ) dut2 (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_rx                 (rx2),
    .i_addr_read          (addr2),
    .o_instr_read         (instr2),
    .o_instr_transmit_done(done2),
    .o_max_addr           (max2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_rx(input bit sel, input logic v);
    if (sel) rx2 = v;
    else rx1 = v;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input logic stop_bit,
                           input int gap_bits);
    drive_rx(sel, 1'b0);
    wait_cycles(BitClk);
    for (int i = 0; i < 8; i++) begin
      drive_rx(sel, b[i]);
      wait_cycles(BitClk);
    end
    drive_rx(sel, stop_bit);
    wait_cycles(BitClk);
    drive_rx(sel, 1'b1);
    wait_cycles(gap_bits * BitClk);
  endtask

  task automatic read_chk(input bit sel, input int a, input logic [15:0] exp, input string tag);
    if (sel) addr2 = a[1:0];
    else addr1 = a[7:0];
    wait_cycles(1);
    check_eq(tag, sel ? instr2 : instr1, exp);
  endtask

  task automatic wait_done1(input int budget, input string tag);
    int n = 0;
    while (!done1 && n < budget) begin
      wait_cycles(1);
      n++;
    end
    check_eq(tag, done1, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cycles(3);
    check_eq("rst_done", done1, 1'b0);
    check_eq("rst_max", max1, 8'h00);
    check_eq("rst_instr", instr1, 16'h0000);
    rst = 1'b0;
    wait_cycles(5);

    // Memory-full stop on the 4-entry instance: done well before any timeout.
    for (int i = 1; i <= 8; i++) send_byte(1'b1, 8'(i), 1'b1, 1);
    check_eq("full_done", done2, 1'b1);
    check_eq("full_max", max2, 2'd3);
    send_byte(1'b1, 8'h09, 1'b1, 1);
    send_byte(1'b1, 8'h0A, 1'b1, 1);
    read_chk(1'b1, 0, 16'h0102, "full_mem0");
    read_chk(1'b1, 3, 16'h0708, "full_mem3");
    check_eq("full_max_after", max2, 2'd3);

    // Test 1: five bytes, odd tail flushed on timeout.
    send_byte(1'b0, 8'hA5, 1'b1, 3);
    send_byte(1'b0, 8'h5A, 1'b1, 3);
    send_byte(1'b0, 8'h3C, 1'b1, 3);
    send_byte(1'b0, 8'h2B, 1'b1, 3);
    send_byte(1'b0, 8'h10, 1'b1, 0);
    wait_cycles(640);
    check_eq("t1_done_early", done1, 1'b0);
    wait_done1(80, "t1_done_timeout");
    check_eq("t1_max", max1, 8'd2);

    // Test 2: read back.
    read_chk(1'b0, 0, 16'hA55A, "t2_mem0");
    read_chk(1'b0, 1, 16'h3C2B, "t2_mem1");
    read_chk(1'b0, 2, 16'h1000, "t2_mem2");

    // Test 3: bytes after done are ignored.
    send_byte(1'b0, 8'h11, 1'b1, 3);
    send_byte(1'b0, 8'h22, 1'b1, 0);
    wait_cycles(800);
    check_eq("t3_done", done1, 1'b1);
    check_eq("t3_max", max1, 8'd2);
    read_chk(1'b0, 0, 16'hA55A, "t3_mem0");
    read_chk(1'b0, 1, 16'h3C2B, "t3_mem1");
    read_chk(1'b0, 2, 16'h1000, "t3_mem2");

    // Test 4: framing error dropped, then 12 34.
    rst = 1'b1;
    wait_cycles(2);
    check_eq("t4_rst_done", done1, 1'b0);
    check_eq("t4_rst_max", max1, 8'h00);
    check_eq("t4_rst_instr", instr1, 16'h0000);
    rst = 1'b0;
    wait_cycles(5);
    send_byte(1'b0, 8'h99, 1'b0, 3);
    send_byte(1'b0, 8'h12, 1'b1, 3);
    send_byte(1'b0, 8'h34, 1'b1, 0);
    wait_done1(800, "t4_done");
    check_eq("t4_max", max1, 8'd0);
    read_chk(1'b0, 0, 16'h1234, "t4_mem0");
    read_chk(1'b0, 1, 16'h3C2B, "t4_mem1_kept");

    // Test 5: quarter-bit glitch produces nothing.
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(5);
    rx1 = 1'b0;
    wait_cycles(BitClk / 4);
    rx1 = 1'b1;
    wait_cycles(900);
    check_eq("t5_done", done1, 1'b0);
    check_eq("t5_max", max1, 8'd0);
    read_chk(1'b0, 0, 16'h1234, "t5_mem0");

    // Test 6: reset after one byte discards the pending high byte.
    send_byte(1'b0, 8'h77, 1'b1, 1);
    rst = 1'b1;
    wait_cycles(2);
    check_eq("t6_rst_done", done1, 1'b0);
    check_eq("t6_rst_max", max1, 8'd0);
    rst = 1'b0;
    wait_cycles(5);
    send_byte(1'b0, 8'hAB, 1'b1, 3);
    send_byte(1'b0, 8'hCD, 1'b1, 0);
    wait_done1(800, "t6_done");
    check_eq("t6_max", max1, 8'd0);
    read_chk(1'b0, 0, 16'hABCD, "t6_mem0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
